// File: rtl/ofifo_pkg.sv
// Shared defaults and pointer-width helper for the per-column output FIFO.
package ofifo_pkg;

  localparam int unsigned DEF_COL    = 8;
  localparam int unsigned DEF_ACT_BW = 4;
  localparam int unsigned DEF_DEPTH  = 64;

  // Address bits for a power-of-two depth; the pointers carry one extra wrap bit.
  function automatic int unsigned ptr_w(input int unsigned d);
    return $clog2(d);
  endfunction

endpackage

// File: rtl/ofifo_col.sv
// One column of the output FIFO: first-word-fall-through storage with
// address+wrap pointers, so all depth entries are usable.
module ofifo_col
  import ofifo_pkg::*;
#(
  parameter int unsigned act_bw = DEF_ACT_BW,
  parameter int unsigned depth  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [act_bw-1:0] in,
  input  logic              rd,
  output logic [act_bw-1:0] out,
  output logic              empty,
  output logic              full
);

  localparam int unsigned AW = ptr_w(depth);

  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic [act_bw-1:0] r_mem [depth];

  logic w_push;
  logic w_pop;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                 (r_wr_ptr[AW] != r_rd_ptr[AW]);

  // Fullness is judged before any pop, so a write to a full column is
  // dropped even when the head leaves in the same cycle.
  assign w_push = wr && !full;
  assign w_pop  = rd && !empty;

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      if (w_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // NOTE: storage has no reset; clearing the pointers is what discards the data.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= in;
  end

  assign out = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/ofifo_4bit.sv
// Output FIFO: col independent column FIFOs popped together as one row.
// Optional sticky per-column overflow flags under OFIFO_OVERFLOW_FLAG_EN.
module ofifo_4bit
  import ofifo_pkg::*;
#(
  parameter int unsigned col    = DEF_COL,
  parameter int unsigned act_bw = DEF_ACT_BW,
  parameter int unsigned depth  = DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [col-1:0]        wr,
  input  logic [col*act_bw-1:0] in,
  input  logic                  rd,
  output logic [col*act_bw-1:0] out,
  output logic                  o_valid,
  output logic                  o_full,
`ifdef OFIFO_OVERFLOW_FLAG_EN
  output logic [col-1:0]        o_overflow,
`endif
  output logic                  o_ready
);

  logic [col-1:0]        w_empty;
  logic [col-1:0]        w_full;
  logic [col*act_bw-1:0] w_col_out;
  logic                  w_rd;

  for (genvar g = 0; g < col; g++) begin : g_col
    ofifo_col #(
      .act_bw (act_bw),
      .depth  (depth)
    ) u_col (
      .clk   (clk),
      .reset (reset),
      .wr    (wr[g]),
      .in    (in[g*act_bw +: act_bw]),
      .rd    (w_rd),
      .out   (w_col_out[g*act_bw +: act_bw]),
      .empty (w_empty[g]),
      .full  (w_full[g])
    );
  end

  // A row exists only once every column has an entry; rows pop atomically.
  assign o_valid = &(~w_empty);
  assign w_rd    = rd && o_valid;
  assign out     = o_valid ? w_col_out : '0;
  assign o_full  = |w_full;
  assign o_ready = ~o_full;

`ifdef OFIFO_OVERFLOW_FLAG_EN
  logic [col-1:0] r_overflow;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_overflow <= '0;
    else        r_overflow <= r_overflow | (wr & w_full);
  end

  assign o_overflow = r_overflow;
`endif

endmodule

// File: tb/tb_ofifo_4bit.sv
// Scoreboard bench for ofifo_4bit: per-column expected queues, rows compared on pop.
module tb_ofifo_4bit;

  localparam int COL   = 8;
  localparam int BW    = 4;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    wr;
  logic [31:0]   in;
  logic          rd;
  logic [31:0]   out;
  logic          o_valid;
  logic          o_full;
  logic          o_ready;
`ifdef OFIFO_OVERFLOW_FLAG_EN
  logic [7:0]    o_overflow;
`endif

  int n_pass  = 0;
  int n_total = 0;

  logic [3:0] q [COL][$];
  logic [7:0] ovf_m;

  always #5 clk = ~clk;

  ofifo_4bit #(.col(COL), .act_bw(BW), .depth(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr      (wr),
    .in      (in),
    .rd      (rd),
    .out     (out),
    .o_valid (o_valid),
    .o_full  (o_full),
`ifdef OFIFO_OVERFLOW_FLAG_EN
    .o_overflow (o_overflow),
`endif
    .o_ready (o_ready)
  );

  function automatic logic model_valid();
    logic v = 1'b1;
    for (int i = 0; i < COL; i++) if (q[i].size() == 0) v = 1'b0;
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < COL; i++) q[i].delete();
    ovf_m = '0;
  endtask

  // Drives one cycle, updates the scoreboard, and returns the row the DUT
  // showed before the edge together with the row the scoreboard expected.
  task automatic step(input logic [7:0] s_wr, input logic [31:0] s_in, input logic s_rd,
                      output logic popped, output logic [31:0] exp_row,
                      output logic [31:0] obs_row);
    logic [7:0] full_b;
    wr = s_wr; in = s_in; rd = s_rd;
    #1;
    obs_row = out;
    popped  = 1'b0;
    exp_row = '0;
    for (int i = 0; i < COL; i++) full_b[i] = (q[i].size() == DEPTH);
    if (s_rd && model_valid()) begin
      popped = 1'b1;
      for (int i = 0; i < COL; i++) exp_row[i*BW +: BW] = q[i].pop_front();
    end
    for (int i = 0; i < COL; i++)
      if (s_wr[i] && !full_b[i]) q[i].push_back(s_in[i*BW +: BW]);
    ovf_m = ovf_m | (s_wr & full_b);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_total++;
    if (o_valid !== 1'b0 || o_full !== 1'b0 || o_ready !== 1'b1 || out !== 32'h0) begin
      $display("FAIL reset_state: valid=%b full=%b ready=%b out=%h want 0/0/1/0",
               o_valid, o_full, o_ready, out);
    end else n_pass++;
`ifdef OFIFO_OVERFLOW_FLAG_EN
    n_total++;
    if (o_overflow !== 8'h00) $display("FAIL reset_ovf: got %h want 00", o_overflow);
    else n_pass++;
`endif
    reset = 1'b1;
    model_clear();
  endtask

  task automatic test_basic();
    logic p; logic [31:0] e, o;
    wr = 8'hFF; in = 32'h76543210; rd = 1'b0;
    #1;
    n_total++;
    if (o_valid !== 1'b0 || out !== 32'h0)
      $display("FAIL basic_no_bypass: valid=%b out=%h want 0/0", o_valid, out);
    else n_pass++;
    step(8'hFF, 32'h76543210, 1'b0, p, e, o);
    n_total++;
    if (o_valid !== 1'b1 || out !== 32'h76543210)
      $display("FAIL basic_row: valid=%b out=%h want 1/76543210", o_valid, out);
    else n_pass++;
    step(8'h00, 32'h0, 1'b1, p, e, o);
    n_total++;
    if (!p || o !== e || o !== 32'h76543210)
      $display("FAIL basic_pop: got %h want %h", o, e);
    else n_pass++;
    n_total++;
    if (o_valid !== 1'b0 || out !== 32'h0)
      $display("FAIL basic_after_pop: valid=%b out=%h want 0/0", o_valid, out);
    else n_pass++;
  endtask

  task automatic test_skew();
    logic p; logic [31:0] e, o;
    for (int k = 0; k < 6; k++) begin
      step((k < 3) ? 8'h01 : 8'hFE, $urandom(), 1'b0, p, e, o);
      n_total++;
      if (o_valid !== (k >= 3))
        $display("FAIL skew_valid_%0d: got %b want %b", k, o_valid, (k >= 3));
      else n_pass++;
    end
    for (int k = 0; k < 3; k++) begin
      step(8'h00, 32'h0, 1'b1, p, e, o);
      n_total++;
      if (!p || o !== e) $display("FAIL skew_pop_%0d: got %h want %h", k, o, e);
      else n_pass++;
    end
    n_total++;
    if (o_valid !== 1'b0) $display("FAIL skew_drained: valid=%b want 0", o_valid);
    else n_pass++;
  endtask

  task automatic test_full();
    logic p; logic [31:0] e, o;
    int bad;
    for (int i = 0; i < DEPTH; i++) begin
      step(8'h01, {28'h0, 4'(i)}, 1'b0, p, e, o);
      if (i == DEPTH - 2) begin
        n_total++;
        if (o_full !== 1'b0) $display("FAIL full_early: o_full=%b want 0", o_full);
        else n_pass++;
      end
    end
    n_total++;
    if (o_full !== 1'b1 || o_ready !== 1'b0 || o_valid !== 1'b0)
      $display("FAIL full_flags: full=%b ready=%b valid=%b want 1/0/0", o_full, o_ready, o_valid);
    else n_pass++;
    step(8'h01, 32'h0000000F, 1'b0, p, e, o);
    n_total++;
    if (o_full !== 1'b1) $display("FAIL full_after_drop: o_full=%b want 1", o_full);
    else n_pass++;
`ifdef OFIFO_OVERFLOW_FLAG_EN
    n_total++;
    if (o_overflow !== 8'h01) $display("FAIL ovf_col0: got %h want 01", o_overflow);
    else n_pass++;
`endif
    for (int i = 0; i < DEPTH; i++) step(8'hFE, $urandom(), 1'b0, p, e, o);
    step(8'hFF, 32'hAAAAAAAA, 1'b1, p, e, o);
    n_total++;
    if (!p || o !== e) $display("FAIL full_pop_with_write: got %h want %h", o, e);
    else n_pass++;
`ifdef OFIFO_OVERFLOW_FLAG_EN
    n_total++;
    if (o_overflow !== ovf_m) $display("FAIL ovf_all: got %h want %h", o_overflow, ovf_m);
    else n_pass++;
`endif
    bad = 0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      step(8'h00, 32'h0, 1'b1, p, e, o);
      if (!p || o !== e) begin
        bad++;
        if (bad < 4) $display("FAIL full_drain_%0d: got %h want %h", i, o, e);
      end
    end
    n_total++;
    if (bad != 0) $display("FAIL full_drain: %0d bad rows, want 0", bad);
    else n_pass++;
    n_total++;
    if (o_valid !== 1'b0 || o_full !== 1'b0)
      $display("FAIL full_empty_after: valid=%b full=%b want 0/0", o_valid, o_full);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic p; logic [31:0] e, o;
    int bad;
    for (int i = 0; i < 5; i++) step(8'hFF, $urandom(), 1'b0, p, e, o);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step(8'hFF, $urandom(), 1'b1, p, e, o);
      if (!p || o !== e || o_valid !== 1'b1 || o_full !== 1'b0) begin
        bad++;
        if (bad < 4) $display("FAIL b2b_%0d: got %h want %h valid=%b", i, o, e, o_valid);
      end
    end
    n_total++;
    if (bad != 0) $display("FAIL b2b: %0d bad cycles, want 0", bad);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      step(8'h00, 32'h0, 1'b1, p, e, o);
      n_total++;
      if (!p || o !== e) $display("FAIL b2b_drain_%0d: got %h want %h", i, o, e);
      else n_pass++;
      if (i == 3) begin
        n_total++;
        if (o_valid !== 1'b1) $display("FAIL b2b_occ4: valid=%b want 1", o_valid);
        else n_pass++;
      end
    end
    n_total++;
    if (o_valid !== 1'b0) $display("FAIL b2b_occ5: valid=%b want 0", o_valid);
    else n_pass++;
  endtask

  task automatic test_ignored_read();
    logic p; logic [31:0] e, o;
    step(8'h7F, 32'h01234567, 1'b0, p, e, o);
    step(8'h7F, 32'h89ABCDEF, 1'b0, p, e, o);
    step(8'h00, 32'h0, 1'b1, p, e, o);
    n_total++;
    if (o_valid !== 1'b0 || out !== 32'h0)
      $display("FAIL ign_rd: valid=%b out=%h want 0/0", o_valid, out);
    else n_pass++;
    step(8'h80, 32'h50000000, 1'b0, p, e, o);
    step(8'h80, 32'hC0000000, 1'b0, p, e, o);
    step(8'h00, 32'h0, 1'b1, p, e, o);
    n_total++;
    if (!p || o !== 32'h51234567) $display("FAIL ign_row0: got %h want 51234567", o);
    else n_pass++;
    step(8'h00, 32'h0, 1'b1, p, e, o);
    n_total++;
    if (!p || o !== 32'hC9ABCDEF) $display("FAIL ign_row1: got %h want c9abcdef", o);
    else n_pass++;
    n_total++;
    if (o_valid !== 1'b0) $display("FAIL ign_empty: valid=%b want 0", o_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic p; logic [31:0] e, o;
    for (int i = 0; i < 10; i++) step(8'hFF, $urandom(), 1'b0, p, e, o);
    step(8'h01, 32'h0, 1'b0, p, e, o);
    n_total++;
    if (o_valid !== 1'b1) $display("FAIL mid_prefill: valid=%b want 1", o_valid);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_total++;
    if (o_valid !== 1'b0 || o_full !== 1'b0 || o_ready !== 1'b1 || out !== 32'h0)
      $display("FAIL mid_async: valid=%b full=%b ready=%b out=%h want 0/0/1/0",
               o_valid, o_full, o_ready, out);
    else n_pass++;
    wr = 8'hFF; in = 32'hFFFFFFFF; rd = 1'b1;
    @(posedge clk);
    #1;
    n_total++;
    if (o_valid !== 1'b0 || out !== 32'h0)
      $display("FAIL mid_ignore: valid=%b out=%h want 0/0", o_valid, out);
    else n_pass++;
`ifdef OFIFO_OVERFLOW_FLAG_EN
    n_total++;
    if (o_overflow !== 8'h00) $display("FAIL mid_ovf: got %h want 00", o_overflow);
    else n_pass++;
`endif
    wr = 8'h00; rd = 1'b0;
    reset = 1'b1;
    model_clear();
    step(8'hFF, 32'h13579BDF, 1'b0, p, e, o);
    n_total++;
    if (o_valid !== 1'b1 || out !== 32'h13579BDF)
      $display("FAIL mid_first_write: valid=%b out=%h want 1/13579bdf", o_valid, out);
    else n_pass++;
  endtask

  initial begin
    reset = 1'b0; wr = '0; in = '0; rd = 1'b0;
    ovf_m = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_skew();
    test_full();
    test_back_to_back();
    test_ignored_read();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
